pwm_output_stage: RTL and testbench

Output stage directly downstream of the wave generator controllers. It sums `NUM_VOICES` voice `Waveform` buses, applies a master volume and drives a single-bit PWM audio pin. It also reports a per-period sample strobe and a peak-level meter. This is the only block that touches the physical audio output.

---
 rtl/synth_pkg.sv | 13 +
 rtl/pwm_modulator.sv | 62 ++++++
 rtl/pwm_output_stage.sv | 101 ++++++++++
 tb/tb_pwm_output_stage.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/synth_pkg.sv
// Shared constants and width helpers for the synth audio path.
package synth_pkg;

    localparam int unsigned VOLUME_W     = 8;
    localparam logic [7:0]  VOLUME_UNITY = 8'hFF;

    // Mix width: wide enough that summing every voice at full scale cannot overflow.
    function automatic int unsigned sum_width(input int unsigned wave_depth,
                                              input int unsigned num_voices);
        return wave_depth + $clog2(num_voices);
    endfunction

endpackage

// File: rtl/pwm_modulator.sv
// PWM modulator: free-running period counter, period-latched duty, registered pin.
// Ports:
//   clk_i, rst_ni   : clock, async active-low reset
//   scaled_i        : candidate duty, sampled only on the wrap cycle
//   mute_i          : forces the next loaded duty to 0
//   pwm_o           : registered PWM pin
//   strobe_o        : one-cycle pulse when the new duty becomes visible (count = 0)
//   wrap_c_o        : combinational, high on the cycle count is at its maximum
//   duty_next_c_o   : combinational, the value duty takes on the coming edge
module pwm_modulator #(
    parameter int unsigned SUM_W = 10
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [SUM_W-1:0] scaled_i,
    input  logic             mute_i,
    output logic             pwm_o,
    output logic             strobe_o,
    output logic             wrap_c_o,
    output logic [SUM_W-1:0] duty_next_c_o
);

    localparam logic [SUM_W-1:0] COUNT_MAX = '1;

    logic [SUM_W-1:0] count_q, count_d;
    logic [SUM_W-1:0] duty_q,  duty_d;
    logic             pwm_q,   pwm_d;
    logic             strobe_q, strobe_d;
    logic             wrap_c;

    // Next-state: duty only moves at the period boundary so the pulse never glitches.
    always_comb begin
        wrap_c   = (count_q == COUNT_MAX);
        count_d  = count_q + SUM_W'(1);
        duty_d   = duty_q;
        if (wrap_c) begin
            duty_d = mute_i ? '0 : scaled_i;
        end
        pwm_d    = (count_q < duty_q);
        strobe_d = wrap_c;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q  <= '0;
            duty_q   <= '0;
            pwm_q    <= 1'b0;
            strobe_q <= 1'b0;
        end else begin
            count_q  <= count_d;
            duty_q   <= duty_d;
            pwm_q    <= pwm_d;
            strobe_q <= strobe_d;
        end
    end

    assign pwm_o         = pwm_q;
    assign strobe_o      = strobe_q;
    assign wrap_c_o      = wrap_c;
    assign duty_next_c_o = duty_d;

endmodule

// File: rtl/pwm_output_stage.sv
// Audio output stage: mixes enabled voices, applies master volume, drives a PWM pin
// and tracks the peak duty loaded.
// Ports:
//   Clock, Reset    : clock, async active-low reset
//   Waveforms       : NUM_VOICES packed unsigned voice samples
//   VoiceEnable     : per-voice mix enable
//   Volume          : master gain (Volume+1)/256
//   Mute            : forces duty 0 from the next period boundary
//   PeakClear       : clears the peak meter (or reloads it when on the wrap cycle)
//   PwmOut          : registered PWM pin
//   SampleStrobe    : one-cycle pulse when a new duty is loaded
//   PeakLevel       : maximum duty loaded since reset or the last clear
module pwm_output_stage
    import synth_pkg::*;
#(
    parameter  int unsigned WAVE_DEPTH = 8,
    parameter  int unsigned NUM_VOICES = 4,
    localparam int unsigned SUM_W      = sum_width(WAVE_DEPTH, NUM_VOICES)
) (
    input  logic                             Clock,
    input  logic                             Reset,
    input  logic [NUM_VOICES*WAVE_DEPTH-1:0] Waveforms,
    input  logic [NUM_VOICES-1:0]            VoiceEnable,
    input  logic [VOLUME_W-1:0]              Volume,
    input  logic                             Mute,
    input  logic                             PeakClear,
    output logic                             PwmOut,
    output logic                             SampleStrobe,
    output logic [SUM_W-1:0]                 PeakLevel
);

    localparam int unsigned GAIN_W = VOLUME_W + 1;
    localparam int unsigned PROD_W = SUM_W + GAIN_W;

    logic [SUM_W-1:0]  sum_q,    sum_d;
    logic [SUM_W-1:0]  scaled_q, scaled_d;
    logic [SUM_W-1:0]  peak_q,   peak_d;
    logic [GAIN_W-1:0] gain_c;
    logic [PROD_W-1:0] prod_c;
    logic              wrap_c;
    logic [SUM_W-1:0]  duty_next_c;

    // Mix stage: full-width sum of enabled voices.
    always_comb begin
        sum_d = '0;
        for (int unsigned i = 0; i < NUM_VOICES; i++) begin
            if (VoiceEnable[i]) begin
                sum_d = sum_d + SUM_W'(Waveforms[i*WAVE_DEPTH +: WAVE_DEPTH]);
            end
        end
    end

    // Gain stage: gain is at most 256/256, so the shifted product never exceeds sum.
    always_comb begin
        gain_c   = GAIN_W'(Volume) + GAIN_W'(1);
        prod_c   = PROD_W'(sum_q) * PROD_W'(gain_c);
        scaled_d = SUM_W'(prod_c >> VOLUME_W);
    end

    // Peak meter: a clear on the wrap cycle restarts the meter at the duty being loaded.
    always_comb begin
        peak_d = peak_q;
        if (wrap_c) begin
            if (PeakClear) begin
                peak_d = duty_next_c;
            end else if (duty_next_c > peak_q) begin
                peak_d = duty_next_c;
            end
        end else if (PeakClear) begin
            peak_d = '0;
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            sum_q    <= '0;
            scaled_q <= '0;
            peak_q   <= '0;
        end else begin
            sum_q    <= sum_d;
            scaled_q <= scaled_d;
            peak_q   <= peak_d;
        end
    end

    pwm_modulator #(
        .SUM_W(SUM_W)
    ) u_modulator (
        .clk_i         (Clock),
        .rst_ni        (Reset),
        .scaled_i      (scaled_q),
        .mute_i        (Mute),
        .pwm_o         (PwmOut),
        .strobe_o      (SampleStrobe),
        .wrap_c_o      (wrap_c),
        .duty_next_c_o (duty_next_c)
    );

    assign PeakLevel = peak_q;

endmodule

// File: tb/tb_pwm_output_stage.sv
// Directed bench for pwm_output_stage (WAVE_DEPTH=8, NUM_VOICES=4, period 1024).
module tb_pwm_output_stage;
    import synth_pkg::*;

    localparam int unsigned PERIOD = 1024;

    logic        clk;
    logic        rst_n;
    logic [31:0] waves;
    logic [3:0]  en;
    logic [7:0]  vol;
    logic        mute;
    logic        pclr;
    logic        pwm;
    logic        strobe;
    logic [9:0]  peak;

    int total;
    int bad;
    int highs;
    int strobes;

    pwm_output_stage #(
        .WAVE_DEPTH(8),
        .NUM_VOICES(4)
    ) dut (
        .Clock        (clk),
        .Reset        (rst_n),
        .Waveforms    (waves),
        .VoiceEnable  (en),
        .Volume       (vol),
        .Mute         (mute),
        .PeakClear    (pclr),
        .PwmOut       (pwm),
        .SampleStrobe (strobe),
        .PeakLevel    (peak)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock: inputs change and outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (pwm === 1'b1) highs++;
        if (strobe === 1'b1) strobes++;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    // Called at the start of a period; runs it fully and checks high count and strobe placement.
    task automatic period(input string tag, input int exp_highs);
        highs = 0; strobes = 0;
        run(PERIOD);
        check({tag, "_highs"}, highs, exp_highs);
        check({tag, "_strobes"}, strobes, 1);
        check({tag, "_strobe_at_end"}, strobe, 1);
    endtask

    initial begin
        total = 0; bad = 0; highs = 0; strobes = 0;
        rst_n = 1'b0;
        waves = 32'hFFFF_FFFF; en = 4'hF; vol = 8'h3C; mute = 1'b0; pclr = 1'b1;

        // Held in reset with arbitrary inputs.
        repeat (5) @(posedge clk);
        #1;
        check("rst_pwm", pwm, 0);
        check("rst_strobe", strobe, 0);
        check("rst_peak", peak, 0);

        // Single voice at 0x80, unity volume, then release.
        waves = 32'h0000_0080; en = 4'b0001; vol = VOLUME_UNITY; pclr = 1'b0;
        rst_n = 1'b1;
        period("p0_first_wrap", 0);
        period("p1_v80", 128);
        check("p1_peak", peak, 128);
        waves = 32'hFFFF_FFFF; en = 4'hF;
        period("p2_v80", 128);

        // All voices full scale, then half volume.
        vol = 8'd127;
        period("p3_full", 1020);
        check("p3_peak", peak, 1020);
        vol = VOLUME_UNITY;
        period("p4_half", 510);

        // Mute mid-period: current pulse completes, next period silent.
        highs = 0; strobes = 0;
        run(500);
        mute = 1'b1;
        run(PERIOD - 500);
        check("p5_muted_mid_highs", highs, 1020);
        check("p5_strobe_at_end", strobe, 1);
        highs = 0; strobes = 0;
        run(10);
        mute = 1'b0;
        run(PERIOD - 10);
        check("p6_muted_highs", highs, 0);
        check("p6_peak", peak, 1020);

        // Peak meter: clear mid-period, then loads of 200 then 100.
        waves = 32'h0000_00C8; en = 4'b0001;
        highs = 0; strobes = 0;
        run(300);
        pclr = 1'b1;
        run(1);
        pclr = 1'b0;
        check("p7_peak_cleared", peak, 0);
        run(PERIOD - 301);
        check("p7_unmuted_highs", highs, 1020);
        check("p7_peak_200", peak, 200);
        waves = 32'h0000_0064;
        period("p8_200", 200);
        check("p8_peak_hold_200", peak, 200);
        highs = 0; strobes = 0;
        run(300);
        pclr = 1'b1;
        run(1);
        pclr = 1'b0;
        check("p9_peak_cleared", peak, 0);
        run(PERIOD - 301);
        check("p9_highs", highs, 100);
        check("p9_peak_100", peak, 100);

        // Clear on the wrap cycle reloads with the new (lower) duty.
        waves = 32'h0000_0032;
        highs = 0; strobes = 0;
        run(PERIOD - 1);
        pclr = 1'b1;
        run(1);
        pclr = 1'b0;
        check("p10_highs", highs, 100);
        check("p10_strobe_at_end", strobe, 1);
        check("p10_peak_wrapclr", peak, 50);

        // Asynchronous reset mid-pulse.
        waves = 32'h0000_00C8;
        highs = 0; strobes = 0;
        run(50);
        check("p11_pwm_high", pwm, 1);
        rst_n = 1'b0;
        #1;
        check("async_rst_pwm", pwm, 0);
        check("async_rst_peak", peak, 0);
        repeat (3) @(posedge clk);
        #1;
        check("async_rst_strobe", strobe, 0);
        rst_n = 1'b1;
        period("post_rst_first", 0);
        period("post_rst_200", 200);
        check("post_rst_peak", peak, 200);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
